// File: rtl/up_reg_pkg.sv
// Shared register map constants for the CPU-visible register bank.
package up_reg_pkg;

  localparam int unsigned REG_ID       = 32'h00;
  localparam int unsigned REG_SCRATCH  = 32'h01;
  localparam int unsigned REG_CTRL     = 32'h02;
  localparam int unsigned REG_PULSE    = 32'h03;
  localparam int unsigned REG_STATUS   = 32'h04;
  localparam int unsigned REG_IRQ_STAT = 32'h05;
  localparam int unsigned REG_IRQ_MASK = 32'h06;
  localparam int unsigned REG_CNT_LO   = 32'h08;
  localparam int unsigned REG_CNT_HI   = 32'h09;

  localparam logic [31:0] RD_UNMAPPED  = 32'h0;

endpackage

// File: rtl/up_reg_slave_if.sv
// Microprocessor bus between the CPU master and the register slave.
interface up_reg_slave_if;
  import up_reg_pkg::*;

  logic        up_cs;
  logic        up_wr;
  logic        up_rd;
  logic [31:0] up_addr;
  logic [31:0] up_data_wr;
  logic [31:0] up_data_rd;

  modport master (
    output up_cs, up_wr, up_rd, up_addr, up_data_wr,
    input  up_data_rd
  );

  modport slave (
    input  up_cs, up_wr, up_rd, up_addr, up_data_wr,
    output up_data_rd
  );

endinterface

// File: rtl/up_reg_slave_strobe_edge.sv
// Block select decode and rising-edge detection of the bus strobes, so a
// strobe held for many cycles yields a single access.
module up_strobe_edge #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          ADDR_W    = 8
) (
  input  logic              up_clk,
  input  logic              up_rst,
  input  logic              up_cs_i,
  input  logic              up_wr_i,
  input  logic              up_rd_i,
  input  logic [31:0]       up_addr_i,
  output logic              wr_go_o,
  output logic              rd_go_o,
  output logic [ADDR_W-1:0] idx_o
);

  logic sel;
  logic wr_act;
  logic rd_act;
  logic prev_wr_q;
  logic prev_rd_q;

  // Select decode, strobe qualification and edge detect; a write that
  // coincides with a read takes priority and the read is dropped.
  always_comb begin
    sel     = (up_addr_i[31:ADDR_W] == BASE_ADDR[31:ADDR_W]);
    wr_act  = up_cs_i & up_wr_i;
    rd_act  = up_cs_i & up_rd_i;
    wr_go_o = wr_act & sel & ~prev_wr_q;
    rd_go_o = rd_act & sel & ~prev_rd_q & ~wr_act;
    idx_o   = up_addr_i[ADDR_W-1:0];
  end

  // Previous-cycle strobe history; cleared by reset so a strobe still held
  // afterwards counts as a fresh edge.
  always_ff @(posedge up_clk) begin
    if (up_rst) begin
      prev_wr_q <= 1'b0;
      prev_rd_q <= 1'b0;
    end else begin
      prev_wr_q <= wr_act;
      prev_rd_q <= rd_act;
    end
  end

endmodule

// File: rtl/up_reg_slave.sv
// CPU-visible register bank: ID, scratch, control with self-clearing
// pulses, live status, sticky W1C interrupt status with mask, and a
// coherent 64-bit counter snapshot (low read latches the high half).
module up_reg_slave
  import up_reg_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          ADDR_W    = 8,
  parameter logic [31:0] ID_VALUE  = 32'h1564_0001,
  parameter logic [31:0] CTRL_RST  = 32'h0000_0000,
  parameter int          PULSE_W   = 8,
  parameter int          EVT_W     = 16
) (
  input  logic               up_clk,
  input  logic               up_rst,
  up_reg_slave_if.slave      bus,
  output logic [31:0]        ctrl_o,
  output logic [PULSE_W-1:0] ctrl_pulse_o,
  input  logic [31:0]        status_i,
  input  logic [EVT_W-1:0]   event_i,
  input  logic [63:0]        cnt_i,
  output logic               irq_o
);

  logic              wr_go;
  logic              rd_go;
  logic [ADDR_W-1:0] idx;

  logic [31:0]        scratch_q,  scratch_d;
  logic [31:0]        ctrl_q,     ctrl_d;
  logic [PULSE_W-1:0] pulse_q,    pulse_d;
  logic [31:0]        status_q,   status_d;
  logic [EVT_W-1:0]   irq_stat_q, irq_stat_d;
  logic [EVT_W-1:0]   irq_mask_q, irq_mask_d;
  logic [31:0]        shadow_q,   shadow_d;
  logic [31:0]        rdata_q,    rdata_d;
  logic               irq_q,      irq_d;

  logic [EVT_W-1:0]   irq_clr;
  logic [31:0]        rd_val;

  up_strobe_edge #(
    .BASE_ADDR (BASE_ADDR),
    .ADDR_W    (ADDR_W)
  ) u_strobe_edge (
    .up_clk    (up_clk),
    .up_rst    (up_rst),
    .up_cs_i   (bus.up_cs),
    .up_wr_i   (bus.up_wr),
    .up_rd_i   (bus.up_rd),
    .up_addr_i (bus.up_addr),
    .wr_go_o   (wr_go),
    .rd_go_o   (rd_go),
    .idx_o     (idx)
  );

  // Read mux over current register contents (pre-update values).
  always_comb begin
    rd_val = RD_UNMAPPED;
    case (idx)
      ADDR_W'(REG_ID):       rd_val = ID_VALUE;
      ADDR_W'(REG_SCRATCH):  rd_val = scratch_q;
      ADDR_W'(REG_CTRL):     rd_val = ctrl_q;
      ADDR_W'(REG_PULSE):    rd_val = RD_UNMAPPED;
      ADDR_W'(REG_STATUS):   rd_val = status_q;
      ADDR_W'(REG_IRQ_STAT): rd_val = 32'(irq_stat_q);
      ADDR_W'(REG_IRQ_MASK): rd_val = 32'(irq_mask_q);
      ADDR_W'(REG_CNT_LO):   rd_val = cnt_i[31:0];
      ADDR_W'(REG_CNT_HI):   rd_val = shadow_q;
      default:               rd_val = RD_UNMAPPED;
    endcase
  end

  // Next-state for every register; events set IRQ bits after the W1C
  // clear so a same-cycle set always survives.
  always_comb begin
    scratch_d  = scratch_q;
    ctrl_d     = ctrl_q;
    irq_mask_d = irq_mask_q;
    shadow_d   = shadow_q;
    rdata_d    = rdata_q;
    irq_clr    = '0;

    if (wr_go) begin
      case (idx)
        ADDR_W'(REG_SCRATCH):  scratch_d  = bus.up_data_wr;
        ADDR_W'(REG_CTRL):     ctrl_d     = bus.up_data_wr;
        ADDR_W'(REG_IRQ_STAT): irq_clr    = bus.up_data_wr[EVT_W-1:0];
        ADDR_W'(REG_IRQ_MASK): irq_mask_d = bus.up_data_wr[EVT_W-1:0];
        default: ;
      endcase
    end

    pulse_d = (wr_go && idx == ADDR_W'(REG_PULSE)) ? bus.up_data_wr[PULSE_W-1:0] : '0;

    if (rd_go) begin
      rdata_d = rd_val;
      if (idx == ADDR_W'(REG_CNT_LO)) begin
        shadow_d = cnt_i[63:32];
      end
    end

    status_d   = status_i;
    irq_stat_d = (irq_stat_q & ~irq_clr) | event_i;
    irq_d      = |(irq_stat_q & irq_mask_q);
  end

  // Register state; reset wins over any same-cycle strobe.
  always_ff @(posedge up_clk) begin
    if (up_rst) begin
      scratch_q  <= '0;
      ctrl_q     <= CTRL_RST;
      pulse_q    <= '0;
      status_q   <= '0;
      irq_stat_q <= '0;
      irq_mask_q <= '0;
      shadow_q   <= '0;
      rdata_q    <= '0;
      irq_q      <= 1'b0;
    end else begin
      scratch_q  <= scratch_d;
      ctrl_q     <= ctrl_d;
      pulse_q    <= pulse_d;
      status_q   <= status_d;
      irq_stat_q <= irq_stat_d;
      irq_mask_q <= irq_mask_d;
      shadow_q   <= shadow_d;
      rdata_q    <= rdata_d;
      irq_q      <= irq_d;
    end
  end

  assign bus.up_data_rd = rdata_q;
  assign ctrl_o         = ctrl_q;
  assign ctrl_pulse_o   = pulse_q;
  assign irq_o          = irq_q;

endmodule

// File: tb/tb_up_reg_slave.sv
// Scoreboard bench for up_reg_slave: expected read data is queued when a
// read is issued and compared when the registered read data appears.
module tb_up_reg_slave;

  localparam logic [31:0] ID_VALUE = 32'h1564_0001;
  localparam logic [31:0] CTRL_RST = 32'h0000_0000;

  logic        up_clk = 1'b0;
  logic        up_rst = 1'b1;
  logic [31:0] ctrl_o;
  logic [7:0]  ctrl_pulse_o;
  logic [31:0] status_i = '0;
  logic [15:0] event_i  = '0;
  logic [63:0] cnt_i    = '0;
  logic        irq_o;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_rd = '0;

  up_reg_slave_if bus();

  up_reg_slave #(
    .BASE_ADDR (32'h0000_0000),
    .ADDR_W    (8),
    .ID_VALUE  (ID_VALUE),
    .CTRL_RST  (CTRL_RST),
    .PULSE_W   (8),
    .EVT_W     (16)
  ) dut (
    .up_clk       (up_clk),
    .up_rst       (up_rst),
    .bus          (bus),
    .ctrl_o       (ctrl_o),
    .ctrl_pulse_o (ctrl_pulse_o),
    .status_i     (status_i),
    .event_i      (event_i),
    .cnt_i        (cnt_i),
    .irq_o        (irq_o)
  );

  always #5 up_clk = ~up_clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic sb_check(input string tag);
    logic [31:0] e;
    e = exp_q.pop_front();
    chk(tag, bus.up_data_rd, e);
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(posedge up_clk);
    @(negedge up_clk);
    bus.up_cs = 1'b1; bus.up_wr = 1'b1; bus.up_addr = a; bus.up_data_wr = d;
    @(posedge up_clk); #1;
    bus.up_cs = 1'b0; bus.up_wr = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, input logic [31:0] exp, input string tag);
    exp_q.push_back(exp);
    @(posedge up_clk);
    @(negedge up_clk);
    bus.up_cs = 1'b1; bus.up_rd = 1'b1; bus.up_addr = a;
    @(posedge up_clk); #1;
    bus.up_cs = 1'b0; bus.up_rd = 1'b0;
    sb_check(tag);
    last_rd = exp;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.up_cs = 1'b0; bus.up_wr = 1'b0; bus.up_rd = 1'b0;
    bus.up_addr = '0; bus.up_data_wr = '0;
    repeat (3) @(posedge up_clk);
    @(negedge up_clk); up_rst = 1'b0;
    #1;
    chk("rst_data_rd", bus.up_data_rd, 32'h0);
    chk("rst_ctrl", ctrl_o, CTRL_RST);
    chk("rst_pulse", ctrl_pulse_o, 8'h0);
    chk("rst_irq", irq_o, 1'b0);

    bus_read(32'h00, ID_VALUE, "rd_id");
    bus_read(32'h02, CTRL_RST, "rd_ctrl_rst");

    bus_write(32'h01, 32'hA5A5_5A5A);
    bus_read(32'h01, 32'hA5A5_5A5A, "rd_scratch");

    // Held write: data changes after the first cycle, only the first lands.
    @(posedge up_clk); @(negedge up_clk);
    bus.up_cs = 1'b1; bus.up_wr = 1'b1; bus.up_addr = 32'h01; bus.up_data_wr = 32'h1111_1111;
    @(posedge up_clk); #1 bus.up_data_wr = 32'h2222_2222;
    repeat (3) @(posedge up_clk);
    #1 bus.up_cs = 1'b0; bus.up_wr = 1'b0;
    bus_read(32'h01, 32'h1111_1111, "held_wr");

    // Held read of STATUS while status_i moves: value must not re-sample.
    status_i = 32'h1234_5678;
    repeat (2) @(posedge up_clk);
    @(negedge up_clk);
    bus.up_cs = 1'b1; bus.up_rd = 1'b1; bus.up_addr = 32'h04;
    exp_q.push_back(32'h1234_5678);
    @(posedge up_clk); #1 status_i = 32'h9999_0000;
    sb_check("held_rd_0");
    for (int i = 1; i < 4; i++) begin
      exp_q.push_back(32'h1234_5678);
      @(posedge up_clk); #1;
      sb_check($sformatf("held_rd_%0d", i));
    end
    bus.up_cs = 1'b0; bus.up_rd = 1'b0;
    last_rd = 32'h1234_5678;

    // Self-clearing pulse.
    bus_write(32'h03, 32'h0000_0081);
    chk("pulse_on", ctrl_pulse_o, 8'h81);
    @(posedge up_clk); #1;
    chk("pulse_off", ctrl_pulse_o, 8'h00);
    bus_read(32'h03, 32'h0, "rd_pulse");

    // Sticky interrupt with mask.
    @(negedge up_clk); event_i = 16'h0008;
    @(negedge up_clk); event_i = 16'h0000;
    bus_read(32'h05, 32'h0000_0008, "irq_stat_set");
    chk("irq_masked", irq_o, 1'b0);
    bus_write(32'h06, 32'h0000_0008);
    chk("irq_lat0", irq_o, 1'b0);
    @(posedge up_clk); #1;
    chk("irq_rise", irq_o, 1'b1);
    @(negedge up_clk); event_i = 16'h0008;
    bus_write(32'h05, 32'h0000_0008);
    event_i = 16'h0000;
    bus_read(32'h05, 32'h0000_0008, "w1c_set_wins");
    chk("irq_held", irq_o, 1'b1);
    bus_write(32'h05, 32'h0000_0008);
    @(posedge up_clk); #1;
    chk("irq_fall", irq_o, 1'b0);
    bus_read(32'h05, 32'h0, "w1c_clear");
    bus_read(32'h06, 32'h0000_0008, "rd_mask");

    // Coherent counter snapshot.
    cnt_i = 64'h0000_0001_FFFF_FFFF;
    bus_read(32'h08, 32'hFFFF_FFFF, "cnt_lo");
    cnt_i = 64'h0000_0002_0000_0000;
    bus_read(32'h09, 32'h0000_0001, "cnt_hi");

    // Simultaneous read and write: write lands, read data unchanged.
    @(posedge up_clk); @(negedge up_clk);
    bus.up_cs = 1'b1; bus.up_rd = 1'b1; bus.up_wr = 1'b1;
    bus.up_addr = 32'h01; bus.up_data_wr = 32'hCAFE_F00D;
    @(posedge up_clk); #1;
    bus.up_cs = 1'b0; bus.up_rd = 1'b0; bus.up_wr = 1'b0;
    chk("rdwr_rd_held", bus.up_data_rd, last_rd);

    // Deselected accesses: no side effects.
    bus_read(32'h0000_0100, last_rd, "desel_rd");
    bus_write(32'h0000_0101, 32'hDEAD_BEEF);
    bus_read(32'h01, 32'hCAFE_F00D, "rdwr_wr_lands");

    // Unmapped index.
    bus_write(32'h07, 32'hFFFF_FFFF);
    bus_read(32'h07, RD_UNMAPPED_TB(), "unmapped");

    // Reset in the middle of a held strobe.
    bus_write(32'h02, 32'h0000_0005);
    chk("ctrl_wr", ctrl_o, 32'h0000_0005);
    @(negedge up_clk); event_i = 16'h0008;
    @(negedge up_clk); event_i = 16'h0000;
    @(posedge up_clk); #1;
    chk("irq_pre_rst", irq_o, 1'b1);
    bus_read(32'h00, ID_VALUE, "rd_id_pre_rst");
    @(negedge up_clk);
    up_rst = 1'b1;
    bus.up_cs = 1'b1; bus.up_wr = 1'b1; bus.up_addr = 32'h02; bus.up_data_wr = 32'h0000_0077;
    @(posedge up_clk); #1;
    chk("mid_rst_ctrl", ctrl_o, CTRL_RST);
    chk("mid_rst_irq", irq_o, 1'b0);
    chk("mid_rst_data_rd", bus.up_data_rd, 32'h0);
    chk("mid_rst_pulse", ctrl_pulse_o, 8'h0);
    @(negedge up_clk); up_rst = 1'b0;
    @(posedge up_clk); #1;
    chk("post_rst_new_edge", ctrl_o, 32'h0000_0077);
    bus.up_cs = 1'b0; bus.up_wr = 1'b0;
    last_rd = 32'h0;
    bus_read(32'h05, 32'h0, "post_rst_irq_stat");
    bus_read(32'h06, 32'h0, "post_rst_mask");
    bus_read(32'h01, 32'h0, "post_rst_scratch");

    chk("sb_drain", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  function automatic logic [31:0] RD_UNMAPPED_TB();
    return 32'h0;
  endfunction

endmodule
